fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV64 pipeline that runs the selection-sort program.
- Owns the program counter and drives the combinational instruction memory's byte address.
- Captures the returned 32-bit word together with its PC into the IF/ID pipeline register.
- Handles load-use stalls from hazard detection, taken-branch redirects/flushes from EX, and halts fetch once the PC runs past the end of the program image.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and loads the IF/ID register.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_bubbles counters.
module fetch_stage #(
   parameter int unsigned          ADDR_W     = 64,
   parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
   parameter int unsigned          PROG_BYTES = 88,
   parameter logic [31:0]          NOP_INST   = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic [31:0]       imem_instruction,
   output logic [ADDR_W-1:0] inst_address,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [31:0]       if_id_instruction,
   output logic              if_id_valid,
`ifdef FETCH_PERF_EN
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_bubbles,
`endif
   output logic              halted
);

   localparam int unsigned INST_W = 32;
   localparam int unsigned PERF_W = 32;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
   logic [INST_W-1:0] if_id_inst_q, if_id_inst_d;
   logic              if_id_valid_q, if_id_valid_d;
   logic              advance, bubble;

   assign halted = (pc_q >= ADDR_W'(PROG_BYTES));

   // Redirect beats stall (older branch), stall beats halt bubbles, halt beats advance.
   always_comb begin
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
      advance       = 1'b0;
      bubble        = 1'b0;
      if (redirect) begin
         pc_d          = redirect_target & ~ADDR_W'(3);
         if_id_pc_d    = '0;
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
         bubble        = 1'b1;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (halted) begin
         if_id_pc_d    = '0;
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
         bubble        = 1'b1;
      end else begin
         pc_d          = pc_q + ADDR_W'(4);
         if_id_pc_d    = pc_q;
         if_id_inst_d  = imem_instruction;
         if_id_valid_d = 1'b1;
         advance       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= '0;
         if_id_inst_q  <= NOP_INST;
         if_id_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   assign inst_address      = pc_q;
   assign if_id_pc          = if_id_pc_q;
   assign if_id_instruction = if_id_inst_q;
   assign if_id_valid       = if_id_valid_q;

`ifdef FETCH_PERF_EN
   logic [PERF_W-1:0] perf_fetched_q, perf_fetched_d;
   logic [PERF_W-1:0] perf_bubbles_q, perf_bubbles_d;

   // Saturating event counters; stall-hold edges count as neither.
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_bubbles_d = perf_bubbles_q;
      if (advance && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + PERF_W'(1);
      if (bubble && (perf_bubbles_q != '1))  perf_bubbles_d = perf_bubbles_q + PERF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_fetched_q <= '0;
         perf_bubbles_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`else
   logic unused_events;
   assign unused_events = advance ^ bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage; expectations queued per step, popped after each edge.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct {
      string       tag;
      logic [63:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic [63:0] addr;
      logic        halt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [63:0] redirect_target;
   logic [31:0] imem_instruction;
   logic [63:0] inst_address, if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid, halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_bubbles;
`endif

   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   logic [31:0] prog [32];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .imem_instruction(imem_instruction),
      .inst_address(inst_address), .if_id_pc(if_id_pc),
      .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
      .halted(halted)
   );

   // Combinational instruction memory holding the 88-byte program image.
   always_comb begin
      imem_instruction = 32'h0;
      if (inst_address < 64'd88) imem_instruction = prog[inst_address[6:2]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one edge's inputs, queue its expected result, then compare after the edge.
   task automatic step(input string tag, input logic rst, input logic st, input logic rd,
                       input logic [63:0] tgt, input logic [63:0] e_pc, input logic [31:0] e_inst,
                       input logic e_valid, input logic [63:0] e_addr, input logic e_halt);
      exp_t e;
      @(negedge clk);
      reset = rst; stall = st; redirect = rd; redirect_target = tgt;
      e.tag = tag; e.pc = e_pc; e.inst = e_inst; e.valid = e_valid;
      e.addr = e_addr; e.halt = e_halt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; failures++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_pc"}, if_id_pc, e.pc);
         chk({e.tag, "_inst"}, 64'(if_id_instruction), 64'(e.inst));
         chk({e.tag, "_valid"}, 64'(if_id_valid), 64'(e.valid));
         chk({e.tag, "_addr"}, inst_address, e.addr);
         chk({e.tag, "_halt"}, 64'(halted), 64'(e.halt));
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) prog[i] = 32'h10000093 + 32'(i << 7);
      prog[0]  = 32'h00000913; prog[1] = 32'h00000433; prog[2] = 32'h04b40863;
      prog[3]  = 32'h00800eb3; prog[4] = 32'h000409b3; prog[19] = 32'h00140413;
      reset = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_target = 64'h40;

      // Reset wins over stall and redirect.
      step("rst0", 0, 1, 1, 64'h40, 64'h0, NOP, 0, 64'h0, 0);
      step("rst1", 0, 1, 1, 64'h40, 64'h0, NOP, 0, 64'h0, 0);

      step("seq0", 1, 0, 0, 64'h0, 64'h0, 32'h00000913, 1, 64'h4, 0);
      step("seq1", 1, 0, 0, 64'h0, 64'h4, 32'h00000433, 1, 64'h8, 0);
      step("seq2", 1, 0, 0, 64'h0, 64'h8, 32'h04b40863, 1, 64'hC, 0);
      step("seq3", 1, 0, 0, 64'h0, 64'hC, 32'h00800eb3, 1, 64'h10, 0);

      step("stl0", 1, 1, 0, 64'h0, 64'hC, 32'h00800eb3, 1, 64'h10, 0);
      step("stl1", 1, 1, 0, 64'h0, 64'hC, 32'h00800eb3, 1, 64'h10, 0);
      step("stlr", 1, 0, 0, 64'h0, 64'h10, 32'h000409b3, 1, 64'h14, 0);

      step("rdst", 1, 1, 1, 64'h4E, 64'h0, NOP, 0, 64'h4C, 0);
      step("rdnv", 1, 1, 0, 64'h0, 64'h0, NOP, 0, 64'h4C, 0);
      step("rdnx", 1, 0, 0, 64'h0, 64'h4C, 32'h00140413, 1, 64'h50, 0);
      step("run20", 1, 0, 0, 64'h0, 64'h50, prog[20], 1, 64'h54, 0);
      step("run21", 1, 0, 0, 64'h0, 64'h54, prog[21], 1, 64'h58, 1);

      step("hlt0", 1, 0, 0, 64'h0, 64'h0, NOP, 0, 64'h58, 1);
      step("hlt1", 1, 0, 0, 64'h0, 64'h0, NOP, 0, 64'h58, 1);
      step("hlt2", 1, 0, 0, 64'h0, 64'h0, NOP, 0, 64'h58, 1);
      step("hltst", 1, 1, 0, 64'h0, 64'h0, NOP, 0, 64'h58, 1);
      step("resm", 1, 0, 1, 64'h8, 64'h0, NOP, 0, 64'h8, 0);
      step("resn", 1, 0, 0, 64'h0, 64'h8, 32'h04b40863, 1, 64'hC, 0);

      // Redirect to exactly PROG_BYTES halts; a far target stays halted without advancing.
      step("rdeq", 1, 0, 1, 64'h58, 64'h0, NOP, 0, 64'h58, 1);
      step("rdhi", 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, NOP, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      step("rdhh", 1, 0, 0, 64'h0, 64'h0, NOP, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      step("rdlo", 1, 0, 1, 64'h57, 64'h0, NOP, 0, 64'h54, 0);
      step("rdl1", 1, 0, 0, 64'h0, 64'h54, prog[21], 1, 64'h58, 1);

      // Counters after 5 advances and 1 redirect, then a one-edge reset at pc=40.
      step("prst", 0, 0, 0, 64'h0, 64'h0, NOP, 0, 64'h0, 0);
      for (int i = 0; i < 5; i++)
         step("padv", 1, 0, 0, 64'h0, 64'(i * 4), prog[i], 1, 64'((i + 1) * 4), 0);
      step("prd", 1, 0, 1, 64'h28, 64'h0, NOP, 0, 64'h28, 0);
`ifdef FETCH_PERF_EN
      chk("perf_fetched5", 64'(perf_fetched), 64'd5);
      chk("perf_bubbles1", 64'(perf_bubbles), 64'd1);
`endif
      step("pmid", 0, 0, 0, 64'h0, 64'h0, NOP, 0, 64'h0, 0);
`ifdef FETCH_PERF_EN
      chk("perf_fetched0", 64'(perf_fetched), 64'd0);
      chk("perf_bubbles0", 64'(perf_bubbles), 64'd0);
`endif
      step("post", 1, 0, 0, 64'h0, 64'h0, 32'h00000913, 1, 64'h4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
